// File: rtl/hough_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hough_pkg : shared constants, FSM state type and r-offset helper      |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
package hough_pkg;

  localparam int ANGLE_W           = 8;
  localparam int DEFAULT_TRIG_FRAC = 12;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // Bias that maps the most negative r to accumulator row 0.
  function automatic int r_offset(input int r_w);
    return 1 << (r_w - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hough_vote_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hough_vote_engine_if : pixel-in / vote-out stream bundle              |
// | Revision             : 1.0                                            |
// +----------------------------------------------------------------------+
interface hough_vote_engine_if
  import hough_pkg::*;
#(
  parameter int X_W = 10,
  parameter int Y_W = 9,
  parameter int R_W = 12
);

  logic               pixel_valid;
  logic               pixel_ready;
  logic [X_W-1:0]     pixel_x;
  logic [Y_W-1:0]     pixel_y;
  logic               vote_valid;
  logic               vote_ready;
  logic [R_W-1:0]     vote_r;
  logic [ANGLE_W-1:0] vote_theta;
  logic               vote_last;
  logic               busy;

  modport slave (
    input  pixel_valid, pixel_x, pixel_y, vote_ready,
    output pixel_ready, vote_valid, vote_r, vote_theta, vote_last, busy
  );

  modport master (
    output pixel_valid, pixel_x, pixel_y, vote_ready,
    input  pixel_ready, vote_valid, vote_r, vote_theta, vote_last, busy
  );

endinterface
`default_nettype wire

// File: rtl/hough_trig_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hough_trig_rom : combinational 256-code cos/sin table, 256 codes=180  |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module hough_trig_rom
  import hough_pkg::*;
#(
  parameter int TRIG_FRAC = DEFAULT_TRIG_FRAC
) (
  input  logic [ANGLE_W-1:0]          code,
  output logic signed [TRIG_FRAC+1:0] cos_val,
  output logic signed [TRIG_FRAC+1:0] sin_val
);

  localparam int     TRIG_W  = TRIG_FRAC + 2;
  localparam longint PI_Q30  = 64'sd3373259426;

  // Round-to-nearest sin(code*pi/256) in Q30 integer Taylor form; code spans 512 per turn.
  function automatic logic signed [TRIG_W-1:0] sin_code(input int code_in);
    longint k, x, term, s;
    bit     neg;
    k   = longint'(code_in % 512);
    neg = 1'b0;
    if (k >= 256) begin
      k   = k - 256;
      neg = 1'b1;
    end
    if (k > 128) k = 256 - k;
    x    = (k * PI_Q30) / 256;
    term = x;
    s    = x;
    for (int n = 1; n <= 8; n++) begin
      term = (term * x) >>> 30;
      term = -((term * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    s = ((s <<< TRIG_FRAC) + (64'sd1 <<< 29)) >>> 30;
    return TRIG_W'(neg ? -s : s);
  endfunction

  logic signed [TRIG_W-1:0] cos_tab [256];
  logic signed [TRIG_W-1:0] sin_tab [256];

  for (genvar i = 0; i < 256; i++) begin : g_rom
    assign sin_tab[i] = sin_code(i);
    assign cos_tab[i] = sin_code(i + 128);
  end

  assign cos_val = cos_tab[code];
  assign sin_val = sin_tab[code];

endmodule
`default_nettype wire

// File: rtl/hough_vote_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hough_vote_engine : per-pixel (r,theta) vote sweep, valid/ready out   |
// | Option macro HOUGH_R_OFFSET_EN : emit r biased by 2^(R_W-1)           |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module hough_vote_engine
  import hough_pkg::*;
#(
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int N_THETA    = 45,
  parameter int THETA_STEP = 4,
  parameter int TRIG_FRAC  = DEFAULT_TRIG_FRAC,
  parameter int R_W        = 12
) (
  input  logic                clk,
  input  logic                reset,
  hough_vote_engine_if.slave  bus
);

  localparam int TRIG_W = TRIG_FRAC + 2;
  localparam int IDX_W  = $clog2(N_THETA + 1);
  localparam int MXY_W  = (X_W > Y_W) ? X_W : Y_W;
  localparam int ACC_W  = MXY_W + TRIG_W + 2;
  localparam int SH_W   = ((ACC_W > R_W + TRIG_FRAC) ? ACC_W : R_W + TRIG_FRAC) + 1;
  localparam logic [IDX_W-1:0] N_IDX = IDX_W'(N_THETA);

  state_t                   state;
  logic [X_W-1:0]           x_q;
  logic [Y_W-1:0]           y_q;
  logic [IDX_W-1:0]         idx;

  logic                     s1_valid;
  logic                     s1_last;
  logic [ANGLE_W-1:0]       s1_theta;
  logic signed [TRIG_W-1:0] s1_cos;
  logic signed [TRIG_W-1:0] s1_sin;

  logic                     vote_valid;
  logic                     vote_last;
  logic [R_W-1:0]           vote_r;
  logic [ANGLE_W-1:0]       vote_theta;

  logic [ANGLE_W-1:0]       theta_code;
  logic signed [TRIG_W-1:0] rom_cos;
  logic signed [TRIG_W-1:0] rom_sin;
  logic                     advance;
  logic                     more;

  logic signed [SH_W-1:0]   sx, sy, sc, ss, acc;
  logic [R_W-1:0]           r_trunc;
  logic [R_W-1:0]           r_out;
  logic                     unused_acc_bits;

  assign theta_code = ANGLE_W'(idx * THETA_STEP);

  hough_trig_rom #(
    .TRIG_FRAC (TRIG_FRAC)
  ) u_rom (
    .code    (theta_code),
    .cos_val (rom_cos),
    .sin_val (rom_sin)
  );

  // Trig stage and vote register shift together, so one stalled cycle costs one cycle.
  assign advance = !vote_valid || bus.vote_ready;
  assign more    = (idx < N_IDX);

  assign sx  = SH_W'($signed({1'b0, x_q}));
  assign sy  = SH_W'($signed({1'b0, y_q}));
  assign sc  = SH_W'(s1_cos);
  assign ss  = SH_W'(s1_sin);
  assign acc = sx * sc + sy * ss;

  // Slicing above the fraction is the floor shift followed by truncation to R_W.
  assign r_trunc         = acc[TRIG_FRAC +: R_W];
  assign unused_acc_bits = ^{acc[TRIG_FRAC-1:0], acc[SH_W-1:TRIG_FRAC+R_W]};

`ifdef HOUGH_R_OFFSET_EN
  localparam logic [R_W-1:0] R_OFF = R_W'(r_offset(R_W));
  assign r_out = r_trunc + R_OFF;
`else
  assign r_out = r_trunc;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      idx        <= '0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_theta   <= '0;
      s1_cos     <= '0;
      s1_sin     <= '0;
      vote_valid <= 1'b0;
      vote_last  <= 1'b0;
      vote_r     <= '0;
      vote_theta <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.pixel_valid) begin
            x_q   <= bus.pixel_x;
            y_q   <= bus.pixel_y;
            idx   <= '0;
            state <= SWEEP;
          end
        end
        SWEEP: begin
          if (advance) begin
            vote_valid <= s1_valid;
            vote_last  <= s1_last;
            vote_theta <= s1_theta;
            vote_r     <= r_out;
            s1_valid   <= more;
            if (more) begin
              s1_cos   <= rom_cos;
              s1_sin   <= rom_sin;
              s1_theta <= theta_code;
              s1_last  <= (idx == N_IDX - IDX_W'(1));
              idx      <= idx + IDX_W'(1);
            end
            if (vote_valid && vote_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pixel_ready = (state == IDLE);
  assign bus.busy        = (state == SWEEP) || vote_valid;
  assign bus.vote_valid  = vote_valid;
  assign bus.vote_last   = vote_last;
  assign bus.vote_r      = vote_r;
  assign bus.vote_theta  = vote_theta;

endmodule
`default_nettype wire

// File: tb/tb_hough_vote_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hough_vote_engine : directed vectors, queue scoreboard, monitor    |
// | Revision             : 1.0                                            |
// +----------------------------------------------------------------------+
module tb_hough_vote_engine;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hough_vote_engine_if #(.X_W(10), .Y_W(9), .R_W(12)) bus ();

  hough_vote_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] theta;
    bit         last;
    bit         chk_r;
    int         lo;
    int         hi;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  function automatic int r_signed(input logic [11:0] v);
`ifdef HOUGH_R_OFFSET_EN
    return int'(v) - 2048;
`else
    return int'($signed(v));
`endif
  endfunction

  // Hand-computed r at selected angles; mode 0 expects r=0 at every angle.
  task automatic push_sweep(input int mode);
    for (int i = 0; i < 45; i++) begin
      exp_t e;
      e.theta = 8'(i * 4);
      e.last  = (i == 44);
      e.chk_r = 1'b0;
      e.lo    = 0;
      e.hi    = 0;
      case (mode)
        0: e.chk_r = 1'b1;
        1: begin
          if (i == 0)  begin e.chk_r = 1'b1; e.lo = 100; e.hi = 100; end
          if (i == 32) begin e.chk_r = 1'b1; e.lo = -1;  e.hi = 0;   end
          if (i == 44) begin e.chk_r = 1'b1; e.lo = -56; e.hi = -56; end
        end
        2: begin
          if (i == 0)  begin e.chk_r = 1'b1; e.lo = 0;   e.hi = 0;   end
          if (i == 16) begin e.chk_r = 1'b1; e.lo = 70;  e.hi = 70;  end
          if (i == 32) begin e.chk_r = 1'b1; e.lo = 100; e.hi = 100; end
        end
        default: begin
          if (i == 0)  begin e.chk_r = 1'b1; e.lo = 639; e.hi = 639; end
          if (i == 16) begin e.chk_r = 1'b1; e.lo = 790; e.hi = 790; end
          if (i == 32) begin e.chk_r = 1'b1; e.lo = 479; e.hi = 479; end
        end
      endcase
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.vote_valid && bus.vote_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_vote: got theta %0d, expected no vote", bus.vote_theta);
      end else begin
        mon_e = sb.pop_front();
        check("vote_theta", int'(bus.vote_theta), int'(mon_e.theta));
        check("vote_last", int'(bus.vote_last), int'(mon_e.last));
        if (mon_e.chk_r)
          check_range("vote_r", r_signed(bus.vote_r), mon_e.lo, mon_e.hi);
      end
    end
  end

  task automatic send(input int x, input int y, input int mode);
    bus.pixel_valid = 1'b1;
    bus.pixel_x     = 10'(x);
    bus.pixel_y     = 9'(y);
    push_sweep(mode);
    @(posedge clk); #1;
    accept_cyc      = cyc;
    bus.pixel_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_len);
    int n = 0;
    while (!bus.pixel_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_len"}, cyc - accept_cyc, exp_len);
    check({name, "_drained"}, sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [20:0] held;
    int          n;
    reset           = 1'b1;
    bus.pixel_valid = 1'b0;
    bus.pixel_x     = '0;
    bus.pixel_y     = '0;
    bus.vote_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel_ready", int'(bus.pixel_ready), 1);
    check("rst_vote_valid", int'(bus.vote_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_vote_last", int'(bus.vote_last), 0);
    check("rst_vote_r", int'(bus.vote_r), 0);
    reset = 1'b0;

    send(0, 0, 0);
    wait_done("origin", 47);
    send(100, 0, 1);
    wait_done("x100", 47);
    send(0, 100, 2);
    wait_done("y100", 47);

    // Backpressure while theta 40 is held.
    send(0, 100, 2);
    n = 0;
    while (!(bus.vote_valid && bus.vote_theta == 8'd40) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_found", int'(n < 100), 1);
    bus.vote_ready = 1'b0;
    held = {bus.vote_r, bus.vote_theta, bus.vote_last};
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_valid", int'(bus.vote_valid), 1);
      check("stall_stable", int'({bus.vote_r, bus.vote_theta, bus.vote_last}), int'(held));
    end
    bus.vote_ready = 1'b1;
    @(posedge clk); #1;
    check("after_stall_theta", int'(bus.vote_theta), 44);
    wait_done("stall", 52);

    // pixel_valid held with changing coordinates across the sweep.
    bus.pixel_valid = 1'b1;
    bus.pixel_x     = 10'd100;
    bus.pixel_y     = 9'd0;
    push_sweep(1);
    @(posedge clk); #1;
    accept_cyc = cyc;
    n = 0;
    while (!bus.pixel_ready && n < 300) begin
      bus.pixel_x = 10'(cyc * 7 + 3);
      bus.pixel_y = 9'(cyc * 3 + 1);
      @(posedge clk); #1;
      n++;
    end
    check("held_len", cyc - accept_cyc, 47);
    check("held_drained", sb.size(), 0);
    bus.pixel_x = 10'd0;
    bus.pixel_y = 9'd0;
    push_sweep(0);
    @(posedge clk); #1;
    accept_cyc      = cyc;
    bus.pixel_valid = 1'b0;
    wait_done("held_next", 47);

    // Reset mid-sweep at vote index 20.
    send(0, 0, 0);
    n = 0;
    while (!(bus.vote_valid && bus.vote_theta == 8'd80) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("idx20_found", int'(n < 100), 1);
    reset = 1'b1;
    #1;
    check("midrst_vote_valid", int'(bus.vote_valid), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_pixel_ready", int'(bus.pixel_ready), 1);
    check("midrst_votes_left", sb.size(), 25);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    send(639, 479, 3);
    wait_done("corner", 47);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hough_vote_engine.md
# hough_vote_engine

Parametrised Hough vote generator: accepts one edge-pixel coordinate per handshake, sweeps a configurable set of quantised angles, and emits one (r, theta) vote per angle on a valid/ready stream. It sits between the edge-pixel scanner and the accumulator RAM controller. It generalises the fixed 45-angle calculator with parametrised coordinate, r and angle widths, and continuous backpressure-safe streaming in place of a fixed every-second-cycle transmit.

## Interface
- X_W, 10: pixel x width (unsigned)
- Y_W, 9: pixel y width (unsigned)
- N_THETA, 45: angles per sweep
- THETA_STEP, 4: angle-code increment per index; angle code is 8 bits, 256 codes = 180°
- TRIG_FRAC, 12: fractional bits of trig constants; TRIG_W = TRIG_FRAC+2 signed
- R_W, 12: vote r width
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pixel_valid  in  1  coordinate offered
- pixel_ready  out  1  engine idle, coordinate will be taken
- pixel_x  in  X_W  edge-pixel column
- pixel_y  in  Y_W  edge-pixel row
- vote_valid  out  1  vote register holds a vote
- vote_ready  in  1  accumulator consumes vote
- vote_r  out  R_W  r for this vote (signed or offset, see Configuration)
- vote_theta  out  8  angle code = index*THETA_STEP
- vote_last  out  1  marks final vote (index N_THETA-1) of the sweep
- busy  out  1  high in SWEEP or while a vote is held

## Operation
- States: IDLE, SWEEP. Reset → IDLE; all outputs 0 except pixel_ready=1.
- IDLE: pixel_ready=1. On pixel_valid&pixel_ready, latch x, y; theta index ← 0; → SWEEP.
- SWEEP: pixel_ready=0; pixel_valid ignored. Vote register loads when it is empty or being consumed (!vote_valid | vote_ready) and index < N_THETA; index then increments.
- Vote arithmetic: cos/sin of angle code from ROM, round-to-nearest of value×2^TRIG_FRAC. acc = x·cos + y·sin in signed full precision (X_W+TRIG_W+1 bits min). r = acc >>> TRIG_FRAC (arithmetic, floor), truncated to R_W; R_W is sized by the integrator so no overflow occurs for in-range x, y.
- vote_last=1 with index N_THETA-1. Handshake on vote_last → IDLE the next cycle; vote register empties unless reloaded.
- vote_r/vote_theta/vote_last stay stable while vote_valid & !vote_ready.
- N_THETA·THETA_STEP ≤ 256 is required; otherwise angle codes wrap mod 256 (no error flag).

## Timing
- Pixel accepted at edge E0; first vote_valid high after E2 (2-cycle latency: latch, then compute+register).
- No backpressure: one vote per cycle, N_THETA consecutive cycles; pixel_ready returns the cycle after the vote_last handshake. Pixel period = N_THETA+2 cycles.
- Backpressure: each low vote_ready cycle stalls sweep by exactly one cycle; no vote dropped or duplicated.
- Reset asserted mid-sweep: immediate return to IDLE, vote_valid=0, index=0; partial sweep discarded.
- vote_ready asserted while vote_valid=0: no effect.

## Configuration
- HOUGH_R_OFFSET_EN defined: vote_r = r + 2^(R_W-1), unsigned accumulator row index (0 ↔ most negative r).
- Undefined: vote_r is two's-complement signed r.

## Structure
- Shared package hough_pkg: angle code width (8), default TRIG_FRAC, state enum {IDLE, SWEEP}, R offset constant function.
- Sub-module hough_trig_rom: combinational 256-entry cos/sin lookup, TRIG_W signed outputs, shared with future inverse-transform blocks.

## Test plan
- Defaults, vote_ready=1, pixel (0,0) → 45 votes, r=0 (2048 with offset), theta 0,4,…,176, vote_last only on 176, pixel_ready high 47 cycles after accept.
- Pixel (100,0) → theta 0 r=100; theta 128 r∈{-1,0}; theta 176 r=-56 (1992 with offset).
- Pixel (0,100) → theta 0 r=0; theta 64 r=70; theta 128 r=100.
- Backpressure: vote_ready low 5 cycles while theta 40 held → outputs stable, then theta 44 next; total 45 votes, sweep 5 cycles longer.
- pixel_valid held high through sweep with changing coordinates → only first coordinate used; next pixel accepted only after vote_last handshake.
- Reset pulsed at vote index 20 → vote_valid=0, busy=0, pixel_ready=1 immediately; new pixel (639,479) then yields full 45-vote sweep from theta 0.
